norm_iter: RTL and testbench



---
 rtl/norm_iter.sv | 202 ++++++++++++++++++++
 tb/tb_norm_iter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_iter.sv
// norm_iter: iterative L1 normalisation of a COL-lane partial-sum row.
// Accumulates the local absolute sum, adds the peer core's sum, then divides
// each lane magnitude (scaled by 2^FRAC) by that sum with a bit-serial
// restoring divider shared across all lanes.
// Optional build macro: NORM_SIGN_EN -- signed output lanes (sign restored,
// magnitude saturated to 2^(BW_PSUM-1)-1). Undefined: unsigned magnitudes.
module norm_iter #(
    parameter int unsigned COL     = 8,
    parameter int unsigned BW_PSUM = 16,
    parameter int unsigned SUM_BW  = 20,
    parameter int unsigned FRAC    = 12
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     acc,
    input  logic                     div,
    input  logic [COL*BW_PSUM-1:0]   sfp_in,
    input  logic [SUM_BW-1:0]        sum_other_core,
    output logic [SUM_BW-1:0]        sum_out,
    output logic [COL*BW_PSUM-1:0]   sfp_out,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     div_zero
);

    localparam int unsigned N     = BW_PSUM + FRAC;   // dividend / quotient width
    localparam int unsigned CNT_W = $clog2(N);
    localparam int unsigned D_W   = SUM_BW + 1;       // two-core divisor width
    localparam int unsigned TRY_W = D_W + 1;          // shifted remainder width

`ifdef NORM_SIGN_EN
    localparam logic [BW_PSUM-1:0] OUT_MAX = {1'b0, {(BW_PSUM-1){1'b1}}};
`else
    localparam logic [BW_PSUM-1:0] OUT_MAX = '1;
`endif
    localparam logic [N-1:0] SAT_LIM = {{FRAC{1'b0}}, OUT_MAX};

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   w_start;
    logic                   w_step;
    logic                   w_finish;
    logic                   w_busy;

    logic [SUM_BW-1:0]      r_sum;
    logic [D_W-1:0]         r_d;
    logic [CNT_W-1:0]       r_cnt;

    // Per-lane dividend/quotient register: the dividend shifts out of the MSB
    // while quotient bits shift into the LSB, so after N steps it holds the quotient.
    logic [N-1:0]           r_qd   [COL];
    logic [D_W-1:0]         r_rem  [COL];
`ifdef NORM_SIGN_EN
    logic                   r_sign [COL];
`endif

    logic [COL*BW_PSUM-1:0] r_sfp_out;
    logic                   r_out_valid;
    logic                   r_div_zero;

    logic [BW_PSUM-1:0]     w_lane    [COL];
    logic [BW_PSUM-1:0]     w_mag     [COL];
    logic [SUM_BW-1:0]      w_sum;
    logic [TRY_W-1:0]       w_trial   [COL];
    logic                   w_ge      [COL];
    logic [D_W-1:0]         w_rem_nxt [COL];
    logic [N-1:0]           w_qd_nxt  [COL];
    logic [BW_PSUM-1:0]     w_magsat  [COL];
    logic [COL*BW_PSUM-1:0] w_sfp_nxt;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; acc has priority over div when both are high
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (div && !acc) w_state_nxt = S_DIV;
            S_DIV:   if (r_cnt == '0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        w_start  = (r_state == S_IDLE) && div && !acc;
        w_step   = (r_state == S_DIV);
        w_finish = (r_state == S_DONE);
        w_busy   = (r_state != S_IDLE);
    end

    // Lane magnitudes and their row sum; -2^(BW_PSUM-1) wraps to 2^(BW_PSUM-1) unsigned
    always_comb begin
        w_sum = '0;
        for (int unsigned i = 0; i < COL; i++) begin
            w_lane[i] = sfp_in[i*BW_PSUM +: BW_PSUM];
            w_mag[i]  = w_lane[i][BW_PSUM-1] ? -w_lane[i] : w_lane[i];
            w_sum     = w_sum + SUM_BW'(w_mag[i]);
        end
    end

    // One restoring-division step for every lane
    always_comb begin
        for (int unsigned i = 0; i < COL; i++) begin
            w_trial[i]   = {r_rem[i], r_qd[i][N-1]};
            w_ge[i]      = (w_trial[i] >= {1'b0, r_d});
            w_rem_nxt[i] = w_ge[i] ? D_W'(w_trial[i] - {1'b0, r_d}) : D_W'(w_trial[i]);
            w_qd_nxt[i]  = {r_qd[i][N-2:0], w_ge[i]};
        end
    end

    // Saturate the finished quotients and pack the output row; D==0 forces zero
    always_comb begin
        w_sfp_nxt = '0;
        for (int unsigned i = 0; i < COL; i++) begin
            w_magsat[i] = (r_qd[i] > SAT_LIM) ? OUT_MAX : r_qd[i][BW_PSUM-1:0];
            if (r_d != '0) begin
`ifdef NORM_SIGN_EN
                w_sfp_nxt[i*BW_PSUM +: BW_PSUM] = r_sign[i] ? -w_magsat[i] : w_magsat[i];
`else
                w_sfp_nxt[i*BW_PSUM +: BW_PSUM] = w_magsat[i];
`endif
            end
        end
    end

    // Local sum register; acc is honoured in every state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sum <= '0;
        end else if (acc) begin
            r_sum <= w_sum;
        end
    end

    // Divider datapath: load on accepted div, iterate while in DIV
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d   <= '0;
            r_cnt <= '0;
            for (int unsigned i = 0; i < COL; i++) begin
                r_qd[i]   <= '0;
                r_rem[i]  <= '0;
`ifdef NORM_SIGN_EN
                r_sign[i] <= 1'b0;
`endif
            end
        end else if (w_start) begin
            r_d   <= {1'b0, r_sum} + {1'b0, sum_other_core};
            r_cnt <= CNT_W'(N - 1);
            for (int unsigned i = 0; i < COL; i++) begin
                r_qd[i]   <= {w_mag[i], {FRAC{1'b0}}};
                r_rem[i]  <= '0;
`ifdef NORM_SIGN_EN
                r_sign[i] <= w_lane[i][BW_PSUM-1];
`endif
            end
        end else if (w_step) begin
            r_cnt <= r_cnt - CNT_W'(1);
            for (int unsigned i = 0; i < COL; i++) begin
                r_qd[i]  <= w_qd_nxt[i];
                r_rem[i] <= w_rem_nxt[i];
            end
        end
    end

    // Result registers: updated only when out_valid pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sfp_out   <= '0;
            r_out_valid <= 1'b0;
            r_div_zero  <= 1'b0;
        end else begin
            r_out_valid <= w_finish;
            if (w_finish) begin
                r_sfp_out  <= w_sfp_nxt;
                r_div_zero <= (r_d == '0);
            end
        end
    end

    assign sum_out   = r_sum;
    assign sfp_out   = r_sfp_out;
    assign out_valid = r_out_valid;
    assign div_zero  = r_div_zero;
    assign busy      = w_busy;

endmodule

// File: tb/tb_norm_iter.sv
// Self-checking bench for norm_iter: directed scenarios plus randomized rows,
// checked against an arithmetic reference (sum of |x|, scaled integer divide).
module tb_norm_iter;

    localparam int COL    = 8;
    localparam int BW     = 16;
    localparam int SUM_BW = 20;
    localparam int FRAC   = 12;
    localparam int N      = BW + FRAC;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 acc;
    logic                 div;
    logic [COL*BW-1:0]    sfp_in;
    logic [SUM_BW-1:0]    sum_other_core;
    logic [SUM_BW-1:0]    sum_out;
    logic [COL*BW-1:0]    sfp_out;
    logic                 out_valid;
    logic                 busy;
    logic                 div_zero;

    int     checks = 0;
    int     errors = 0;
    longint model_sum = 0;

    norm_iter #(.COL(COL), .BW_PSUM(BW), .SUM_BW(SUM_BW), .FRAC(FRAC)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .acc            (acc),
        .div            (div),
        .sfp_in         (sfp_in),
        .sum_other_core (sum_other_core),
        .sum_out        (sum_out),
        .sfp_out        (sfp_out),
        .out_valid      (out_valid),
        .busy           (busy),
        .div_zero       (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic longint mag_of(input logic [15:0] x);
        return x[15] ? (longint'(65536) - longint'(x)) : longint'(x);
    endfunction

    function automatic longint row_sum(input logic [COL*BW-1:0] row);
        longint s = 0;
        for (int i = 0; i < COL; i++) s += mag_of(row[i*BW +: BW]);
        return s % (longint'(1) << SUM_BW);
    endfunction

    function automatic logic [15:0] exp_lane(input logic [15:0] x, input longint d);
        longint q;
        if (d == 0) return 16'd0;
        q = (mag_of(x) << FRAC) / d;
`ifdef NORM_SIGN_EN
        if (q > 32767) q = 32767;
        if (x[15]) q = -q;
`else
        if (q > 65535) q = 65535;
`endif
        return q[15:0];
    endfunction

    function automatic logic [15:0] rand_lane();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom_range(0, 255));
            1:       return 16'h8000;
            2:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic do_acc(input logic [COL*BW-1:0] row);
        sfp_in = row;
        acc    = 1'b1;
        tick();
        acc       = 1'b0;
        model_sum = row_sum(row);
        check("sum_out after acc", sum_out, 32'(model_sum));
    endtask

    // mode 0: plain division; mode 1: extra div at edge 5 and acc at edge 10
    task automatic run_div(input string tag, input logic [COL*BW-1:0] row,
                           input logic [SUM_BW-1:0] other, input int mode);
        longint            d;
        logic [15:0]       exp_row [COL];
        logic [COL*BW-1:0] got_row;
        logic [COL*BW-1:0] row2;
        logic              got_dz;
        int                nvalid;
        int                vedge;
        d = model_sum + longint'(other);
        for (int i = 0; i < COL; i++) exp_row[i] = exp_lane(row[i*BW +: BW], d);
        got_row = '0;
        got_dz  = 1'b0;
        nvalid  = 0;
        vedge   = -1;
        row2    = '0;
        for (int i = 0; i < COL; i++) row2[i*BW +: BW] = 16'd7;

        sfp_in         = row;
        sum_other_core = other;
        div            = 1'b1;
        tick();
        div = 1'b0;
        check({tag, " busy after start"}, 32'(busy), 32'd1);

        for (int e = 1; e <= N + 8; e++) begin
            if (mode == 1 && e == 5) begin
                sfp_in         = ~row;
                sum_other_core = 20'd3;
                div            = 1'b1;
            end
            if (mode == 1 && e == 6) div = 1'b0;
            if (mode == 1 && e == 10) begin
                sfp_in = row2;
                acc    = 1'b1;
            end
            tick();
            if (mode == 1 && e == 10) begin
                acc       = 1'b0;
                model_sum = row_sum(row2);
                check({tag, " sum_out mid-division"}, sum_out, 32'(model_sum));
            end
            if (e == N) check({tag, " busy at edge N"}, 32'(busy), 32'd1);
            if (out_valid) begin
                nvalid++;
                if (vedge < 0) begin
                    vedge   = e;
                    got_row = sfp_out;
                    got_dz  = div_zero;
                end
            end
        end
        check({tag, " out_valid count"}, 32'(nvalid), 32'd1);
        check({tag, " out_valid edge"}, 32'(vedge), 32'(N + 1));
        check({tag, " busy after done"}, 32'(busy), 32'd0);
        check({tag, " div_zero"}, 32'(got_dz), 32'(d == 0));
        for (int i = 0; i < COL; i++)
            check($sformatf("%s lane%0d", tag, i), 32'(got_row[i*BW +: BW]), 32'(exp_row[i]));
        check({tag, " sfp_out held"}, 32'(sfp_out == got_row), 32'd1);
    endtask

    initial begin
        logic [COL*BW-1:0] row;
        logic [COL*BW-1:0] rowb;
        int                nv;

        reset_n        = 1'b0;
        acc            = 1'b0;
        div            = 1'b0;
        sfp_in         = '0;
        sum_other_core = '0;
        tick();
        tick();
        tick();
        check("reset sfp_out", 32'(|sfp_out), 32'd0);
        check("reset sum_out", sum_out, 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset div_zero", 32'(div_zero), 32'd0);
        reset_n = 1'b1;
        tick();

        // Uniform row
        row = '0;
        for (int i = 0; i < COL; i++) row[i*BW +: BW] = 16'd100;
        do_acc(row);
        check("uniform sum 800", sum_out, 32'd800);
        run_div("uniform", row, 20'd0, 0);

        // Two-core sum
        row = '0;
        row[0 +: BW]  = 16'd400;
        row[BW +: BW] = -16'sd400;
        do_acc(row);
        run_div("twocore", row, 20'd800, 0);

        // Saturation
        row = '0;
        row[0 +: BW] = 16'd1;
        do_acc(row);
        row[0 +: BW] = 16'd32767;
        run_div("sat pos", row, 20'd0, 0);
        row[0 +: BW] = 16'h8000;
        run_div("sat min", row, 20'd0, 0);

        // Divide by zero
        do_acc('0);
        row = '0;
        for (int i = 0; i < COL; i++) row[i*BW +: BW] = 16'(i * 37 + 5);
        run_div("divzero", row, 20'd0, 0);

        // Busy/overlap
        row = '0;
        for (int i = 0; i < COL; i++) row[i*BW +: BW] = 16'(100 * (i + 1));
        do_acc(row);
        run_div("overlap", row, 20'd250, 1);

        // acc+div together: acc wins, no division starts
        row = '0;
        for (int i = 0; i < COL; i++) row[i*BW +: BW] = 16'd9;
        sfp_in = row;
        acc    = 1'b1;
        div    = 1'b1;
        tick();
        acc       = 1'b0;
        div       = 1'b0;
        model_sum = row_sum(row);
        check("acc+div sum_out", sum_out, 32'(model_sum));
        check("acc+div busy", 32'(busy), 32'd0);
        nv = 0;
        for (int e = 0; e < N + 4; e++) begin
            tick();
            if (out_valid) nv++;
        end
        check("acc+div no out_valid", 32'(nv), 32'd0);

        // Reset mid-operation
        sfp_in = row;
        div    = 1'b1;
        tick();
        div = 1'b0;
        for (int e = 1; e <= 12; e++) tick();
        #2 reset_n = 1'b0;
        #1;
        check("midrst sfp_out", 32'(|sfp_out), 32'd0);
        check("midrst sum_out", sum_out, 32'd0);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst div_zero", 32'(div_zero), 32'd0);
        tick();
        tick();
        reset_n   = 1'b1;
        model_sum = 0;
        nv = 0;
        for (int e = 0; e < N + 4; e++) begin
            tick();
            if (out_valid) nv++;
        end
        check("midrst no out_valid", 32'(nv), 32'd0);
        do_acc(row);
        run_div("after reset", row, 20'd11, 0);

        // Randomized rows
        for (int t = 0; t < 24; t++) begin
            row  = '0;
            rowb = '0;
            for (int i = 0; i < COL; i++) begin
                row[i*BW +: BW]  = rand_lane();
                rowb[i*BW +: BW] = rand_lane();
            end
            if ($urandom_range(0, 3) != 0) do_acc(row);
            case ($urandom_range(0, 3))
                0:       sum_other_core = 20'd0;
                1:       sum_other_core = 20'($urandom_range(1, 64));
                default: sum_other_core = 20'($urandom);
            endcase
            run_div($sformatf("rand%0d", t), rowb, sum_other_core, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
